// File: rtl/a5_pkg.sv
// Shared CPU package: datapath widths and the one-hot multiply phase encodings
// used by the state/counter controller and the multiply datapath.
package a5_pkg;

  localparam int A5_W  = 8;
  localparam int A5_PW = 2 * A5_W;

  // Bit order matches {MUL4, MUL3, MUL2_2, MUL2_1, MUL1}
  typedef enum logic [4:0] {
    PH_NONE   = 5'b00000,
    PH_MUL1   = 5'b00001,
    PH_MUL2_1 = 5'b00010,
    PH_MUL2_2 = 5'b00100,
    PH_MUL3   = 5'b01000,
    PH_MUL4   = 5'b10000
  } mul_phase_e;

endpackage

// File: rtl/shift_add_unit.sv
// Shift-and-add core: owns {carry, acc_hi, lo} and performs the conditional add
// of the multiplicand and the one-bit right shift of the partial product.
module shift_add_unit
  import a5_pkg::*;
#(
  parameter int W = A5_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         add,
  input  logic         shift,
  input  logic [W-1:0] mcand,
  input  logic [W-1:0] opb,
  output logic [W-1:0] acc_hi,
  output logic [W-1:0] lo
);

  logic         carry;
  logic [W:0]   sum;

  assign sum = {1'b0, acc_hi} + {1'b0, mcand};

  // The caller guarantees load/add/shift are mutually exclusive
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry  <= 1'b0;
      acc_hi <= '0;
      lo     <= '0;
    end else if (load) begin
      carry  <= 1'b0;
      acc_hi <= '0;
      lo     <= opb;
    end else if (add) begin
      if (lo[0]) {carry, acc_hi} <= sum;
    end else if (shift) begin
      {carry, acc_hi, lo} <= {1'b0, carry, acc_hi, lo[W-1:1]};
    end
  end

endmodule

// File: rtl/mul_datapath.sv
// Sequential unsigned multiplier datapath driven by one-hot phase strobes,
// with sequencing cross-checks and a two-byte writeback of the product.
module mul_datapath
  import a5_pkg::*;
#(
  parameter int W = A5_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           MUL1,
  input  logic           MUL2_1,
  input  logic           MUL2_2,
  input  logic           MUL3,
  input  logic           MUL4,
  input  logic [3:0]     counter_q,
  input  logic [W-1:0]   opa,
  input  logic [W-1:0]   opb,
  output logic [W-1:0]   wb_data,
  output logic           wb_lo,
  output logic           wb_hi,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           seq_err
);

  mul_phase_e   phase;
  logic [W-1:0] mcand;
  logic [W-1:0] acc_hi;
  logic [W-1:0] lo;
  logic [2:0]   iter;
  logic         iter_wrapped;
  logic         unused_counter_hi;

  assign phase             = mul_phase_e'({MUL4, MUL3, MUL2_2, MUL2_1, MUL1});
  assign unused_counter_hi = ^counter_q[3:1];

  shift_add_unit #(.W(W)) u_shift_add (
    .clk    (clk),
    .reset  (reset),
    .load   (phase == PH_MUL1),
    .add    ((phase == PH_MUL2_1) && busy),
    .shift  ((phase == PH_MUL2_2) && busy),
    .mcand  (mcand),
    .opb    (opb),
    .acc_hi (acc_hi),
    .lo     (lo)
  );

  // A multi-hot strobe vector falls into the default arm: flag it, touch nothing else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand        <= '0;
      iter         <= '0;
      iter_wrapped <= 1'b0;
      product      <= '0;
      wb_data      <= '0;
      wb_lo        <= 1'b0;
      wb_hi        <= 1'b0;
      busy         <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      wb_lo <= 1'b0;
      wb_hi <= 1'b0;
      case (phase)
        PH_NONE: begin
        end
        PH_MUL1: begin
          mcand        <= opa;
          iter         <= '0;
          iter_wrapped <= 1'b0;
          busy         <= 1'b1;
          seq_err      <= 1'b0;
        end
        PH_MUL2_1: begin
          if (counter_q[0]) seq_err <= 1'b1;
        end
        PH_MUL2_2: begin
          if (!counter_q[0]) seq_err <= 1'b1;
          if (busy) begin
            iter <= iter + 3'd1;
            if (iter == 3'd7) iter_wrapped <= 1'b1;
          end
        end
        PH_MUL3: begin
          // Exactly eight shifts leave iter back at zero with the wrap seen
          if (!busy || (iter != 3'd0) || !iter_wrapped) seq_err <= 1'b1;
          if (busy) begin
            product <= {acc_hi, lo};
            wb_data <= lo;
            wb_lo   <= 1'b1;
          end
        end
        PH_MUL4: begin
          if (busy) begin
            wb_data <= acc_hi;
            wb_hi   <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          seq_err <= 1'b1;
        end
      endcase
    end
  end

endmodule
